// File: rtl/trigout_pkg.sv
// Shared definitions for the trigger-out timestamp FIFO: source bit indices,
// field widths and the stored entry layout.
package trigout_pkg;

  localparam int CH1 = 0;
  localparam int CH2 = 1;
  localparam int CH3 = 2;
  localparam int CH4 = 3;
  localparam int EXT = 4;

  localparam int MASK_W  = 5;
  localparam int SEC_W   = 40;
  localparam int CYC_W   = 28;
  localparam int ENTRY_W = MASK_W + SEC_W + CYC_W;

  typedef struct packed {
    logic [MASK_W-1:0] mask;
    logic [SEC_W-1:0]  sec;
    logic [CYC_W-1:0]  cyc;
  } entry_t;

  typedef enum logic {
    IDLE,
    HOLDOFF
  } hold_state_t;

endpackage

// File: rtl/trigout_ts_fifo_mem.sv
// Synchronous show-ahead FIFO holding timestamp entries; the head entry is
// visible on rd_data whenever the FIFO is not empty.
module trigout_ts_fifo_mem
  import trigout_pkg::*;
#(
  parameter int g_DEPTH = 16
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  entry_t wr_data,
  output entry_t rd_data,
  output logic   empty,
  output logic   full
);

  localparam int AW = (g_DEPTH > 1) ? $clog2(g_DEPTH) : 1;

  logic [ENTRY_W-1:0] store [g_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic               do_push;
  logic               do_pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(g_DEPTH));

  // A pop frees the slot the push needs, so a full FIFO accepts push+pop together.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= wr_data;
  end

  assign rd_data = entry_t'(store[rd_ptr]);

endmodule

// File: rtl/trigout_ts_fifo.sv
// Trigger-out timestamp FIFO: captures enabled trigger pulses with WR time,
// applies a holdoff dead time and queues entries. Macro TRIGOUT_DROP_CNT_EN adds a drop counter.
module trigout_ts_fifo
  import trigout_pkg::*;
#(
  parameter int g_DEPTH   = 16,
  parameter int g_HOLDOFF = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [MASK_W-1:0] trig_i,
  input  logic [MASK_W-1:0] enable_i,
  input  logic [SEC_W-1:0]  tm_sec_i,
  input  logic [CYC_W-1:0]  tm_cycles_i,
  input  logic              pop_i,
  input  logic              ovf_clr_i,
  output logic              ts_present_o,
  output logic [MASK_W-1:0] mask_o,
  output logic [SEC_W-1:0]  ts_sec_o,
  output logic [CYC_W-1:0]  ts_cycles_o,
  output logic              ovf_o,
  output logic [15:0]       drop_cnt_o
);

  localparam logic [MASK_W-1:0] SRC_ALL =
    MASK_W'((1 << CH1) | (1 << CH2) | (1 << CH3) | (1 << CH4) | (1 << EXT));
  localparam logic [15:0] HOLD_LOAD = 16'(g_HOLDOFF);

  entry_t      cap;
  entry_t      head;
  hold_state_t state;
  hold_state_t state_nxt;
  logic [15:0] hold_cnt;
  logic [15:0] hold_nxt;
  logic        accept;
  logic        drop;
  logic        fifo_empty;
  logic        fifo_full;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap <= '0;
    end else begin
      cap.mask <= trig_i & enable_i & SRC_ALL;
      cap.sec  <= tm_sec_i;
      cap.cyc  <= tm_cycles_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // With zero holdoff the FSM never leaves IDLE, allowing one event per cycle.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        if (accept && (HOLD_LOAD != 16'd0)) begin
          state_nxt = HOLDOFF;
          hold_nxt  = HOLD_LOAD;
        end
      end
      HOLDOFF: begin
        hold_nxt = (hold_cnt == 16'd0) ? 16'd0 : hold_cnt - 16'd1;
        if (hold_cnt <= 16'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept = 1'b0;
    if ((state == IDLE) && (cap.mask != '0)) accept = 1'b1;
  end

  assign drop = accept && fifo_full && !pop_i;

  trigout_ts_fifo_mem #(
    .g_DEPTH(g_DEPTH)
  ) u_mem (
    .clk    (clk_i),
    .rst    (rst_i),
    .push   (accept),
    .pop    (pop_i),
    .wr_data(cap),
    .rd_data(head),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // Head fields are forced to zero while empty so stale storage never leaks out.
  assign ts_present_o = !fifo_empty;
  assign mask_o       = ts_present_o ? head.mask : '0;
  assign ts_sec_o     = ts_present_o ? head.sec  : '0;
  assign ts_cycles_o  = ts_present_o ? head.cyc  : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i)          ovf_o <= 1'b0;
    else if (drop)      ovf_o <= 1'b1;
    else if (ovf_clr_i) ovf_o <= 1'b0;
  end

`ifdef TRIGOUT_DROP_CNT_EN
  logic [15:0] drop_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i)                              drop_cnt <= '0;
    else if (ovf_clr_i)                     drop_cnt <= {15'd0, drop};
    else if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
  end

  assign drop_cnt_o = drop_cnt;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_trigout_ts_fifo.sv
// Bench for trigout_ts_fifo: two instances (holdoff 8 and holdoff 0, depth 4)
// driven by shared stimulus and compared against a queue-based reference model.
module tb_trigout_ts_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  trig;
  logic [4:0]  enable;
  logic [39:0] tm_sec;
  logic [27:0] tm_cyc;
  logic        pop;
  logic        ovf_clr;

  logic        present [2];
  logic [4:0]  mask    [2];
  logic [39:0] sec     [2];
  logic [27:0] cyc     [2];
  logic        ovf     [2];
  logic [15:0] dcnt    [2];

  int checks = 0;
  int errors = 0;

`ifdef TRIGOUT_DROP_CNT_EN
  localparam logic [15:0] EXP_DROPS = 16'd2;
`else
  localparam logic [15:0] EXP_DROPS = 16'd0;
`endif

  always #5 clk = ~clk;

  trigout_ts_fifo #(.g_DEPTH(4), .g_HOLDOFF(8)) dut_h (
    .clk_i(clk), .rst_i(rst), .trig_i(trig), .enable_i(enable),
    .tm_sec_i(tm_sec), .tm_cycles_i(tm_cyc), .pop_i(pop), .ovf_clr_i(ovf_clr),
    .ts_present_o(present[0]), .mask_o(mask[0]), .ts_sec_o(sec[0]),
    .ts_cycles_o(cyc[0]), .ovf_o(ovf[0]), .drop_cnt_o(dcnt[0])
  );

  trigout_ts_fifo #(.g_DEPTH(4), .g_HOLDOFF(0)) dut_z (
    .clk_i(clk), .rst_i(rst), .trig_i(trig), .enable_i(enable),
    .tm_sec_i(tm_sec), .tm_cycles_i(tm_cyc), .pop_i(pop), .ovf_clr_i(ovf_clr),
    .ts_present_o(present[1]), .mask_o(mask[1]), .ts_sec_o(sec[1]),
    .ts_cycles_o(cyc[1]), .ovf_o(ovf[1]), .drop_cnt_o(dcnt[1])
  );

  // Reference model: a trigger seen in cycle t is eligible if t >= blocked[d];
  // acceptance blocks the next holdoff cycles. Entries live in plain queues.
  logic [72:0] mq [2][$];
  int          blocked [2];
  logic        movf [2];
  logic [15:0] mdrop [2];
  logic [4:0]  p_mask;
  logic [39:0] p_sec;
  logic [27:0] p_cyc;
  int          p_t;
  int          cyc_n = 0;
  bit          m_acc;
  bit          m_drp;

  function automatic int hold_of(input int d);
    return (d == 0) ? 8 : 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        mq[d].delete();
        blocked[d] = 0;
        movf[d]    = 1'b0;
        mdrop[d]   = 16'd0;
      end
      p_mask = 5'd0;
      p_sec  = 40'd0;
      p_cyc  = 28'd0;
      p_t    = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_acc = (p_mask != 5'd0) && (p_t >= blocked[d]);
        m_drp = m_acc && (mq[d].size() == 4) && !pop;
        if (m_acc) blocked[d] = p_t + hold_of(d) + 1;
        if (pop && (mq[d].size() > 0)) void'(mq[d].pop_front());
        if (m_acc && !m_drp) mq[d].push_back({p_mask, p_sec, p_cyc});
        if (m_drp) movf[d] = 1'b1;
        else if (ovf_clr) movf[d] = 1'b0;
`ifdef TRIGOUT_DROP_CNT_EN
        if (ovf_clr) mdrop[d] = m_drp ? 16'd1 : 16'd0;
        else if (m_drp && (mdrop[d] != 16'hFFFF)) mdrop[d] = mdrop[d] + 16'd1;
`endif
      end
      p_mask = trig & enable;
      p_sec  = tm_sec;
      p_cyc  = tm_cyc;
      p_t    = cyc_n;
    end
    cyc_n++;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; trig = 5'h1F; enable = 5'h1F;
    tm_sec = 40'hFF_FFFF_FFFF; tm_cyc = 28'hFFF_FFFF;
    step();
    rst = 1'b0; trig = 5'h00;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (present[d] !== 1'b0) begin errors++; $display("FAIL reset_present dut%0d: got %b expected 0", d, present[d]); end
      checks++;
      if (mask[d] !== 5'h00) begin errors++; $display("FAIL reset_mask dut%0d: got %h expected 00", d, mask[d]); end
      checks++;
      if (sec[d] !== 40'h0) begin errors++; $display("FAIL reset_sec dut%0d: got %h expected 0", d, sec[d]); end
      checks++;
      if (cyc[d] !== 28'h0) begin errors++; $display("FAIL reset_cyc dut%0d: got %h expected 0", d, cyc[d]); end
      checks++;
      if (ovf[d] !== 1'b0) begin errors++; $display("FAIL reset_ovf dut%0d: got %b expected 0", d, ovf[d]); end
      checks++;
      if (dcnt[d] !== 16'h0) begin errors++; $display("FAIL reset_dcnt dut%0d: got %h expected 0", d, dcnt[d]); end
    end
    step();
    checks++;
    if (present[0] !== 1'b0) begin errors++; $display("FAIL reset_trig_discard: got present=%b expected 0", present[0]); end
  endtask

  task automatic test_single_event();
    enable = 5'h1F; trig = 5'h01;
    tm_sec = 40'h12_3456_789A; tm_cyc = 28'h0ABCDEF;
    step();
    trig = 5'h00;
    checks++;
    if (present[0] !== 1'b0) begin errors++; $display("FAIL single_latency: got present=%b expected 0", present[0]); end
    step();
    checks++;
    if (present[0] !== 1'b1) begin errors++; $display("FAIL single_present: got %b expected 1", present[0]); end
    checks++;
    if (mask[0] !== 5'h01) begin errors++; $display("FAIL single_mask: got %h expected 01", mask[0]); end
    checks++;
    if (sec[0] !== 40'h12_3456_789A) begin errors++; $display("FAIL single_sec: got %h expected 123456789a", sec[0]); end
    checks++;
    if (cyc[0] !== 28'h0ABCDEF) begin errors++; $display("FAIL single_cyc: got %h expected 0abcdef", cyc[0]); end
    pop = 1'b1;
    step();
    pop = 1'b0;
    checks++;
    if (present[0] !== 1'b0) begin errors++; $display("FAIL single_pop: got present=%b expected 0", present[0]); end
    idle(10);
  endtask

  task automatic test_merge();
    enable = 5'h0F; trig = 5'h13; tm_sec = 40'h55; tm_cyc = 28'h66;
    step();
    trig = 5'h00;
    step();
    checks++;
    if (present[0] !== 1'b1) begin errors++; $display("FAIL merge_present: got %b expected 1", present[0]); end
    checks++;
    if (mask[0] !== 5'h03) begin errors++; $display("FAIL merge_mask: got %h expected 03", mask[0]); end
    pop = 1'b1;
    step();
    pop = 1'b0;
    checks++;
    if (present[0] !== 1'b0) begin errors++; $display("FAIL merge_single_entry: got present=%b expected 0", present[0]); end
    enable = 5'h1F;
    idle(10);
  endtask

  task automatic test_holdoff();
    apply_reset();
    enable = 5'h1F;
    for (int c = 0; c < 12; c++) begin
      trig   = (c == 0 || c == 4 || c == 9) ? 5'h01 : 5'h00;
      tm_sec = 40'h100 + 40'(c);
      step();
    end
    trig = 5'h00;
    step();
    checks++;
    if (present[0] !== 1'b1 || sec[0] !== 40'h100) begin
      errors++; $display("FAIL holdoff_first: got present=%b sec=%h expected 1/100", present[0], sec[0]);
    end
    pop = 1'b1;
    step();
    checks++;
    if (present[0] !== 1'b1 || sec[0] !== 40'h109) begin
      errors++; $display("FAIL holdoff_second: got present=%b sec=%h expected 1/109", present[0], sec[0]);
    end
    step();
    pop = 1'b0;
    checks++;
    if (present[0] !== 1'b0) begin errors++; $display("FAIL holdoff_count: got present=%b expected 0", present[0]); end
    checks++;
    if (dcnt[0] !== 16'h0 || ovf[0] !== 1'b0) begin
      errors++; $display("FAIL holdoff_nodrop: got dcnt=%h ovf=%b expected 0/0", dcnt[0], ovf[0]);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    enable = 5'h1F;
    for (int c = 0; c < 6; c++) begin
      trig = 5'h01; tm_sec = 40'h200 + 40'(c);
      step();
    end
    trig = 5'h00;
    step();
    checks++;
    if (ovf[1] !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ovf[1]); end
    checks++;
    if (dcnt[1] !== EXP_DROPS) begin errors++; $display("FAIL ovf_dcnt: got %0d expected %0d", dcnt[1], EXP_DROPS); end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    checks++;
    if (ovf[1] !== 1'b0 || dcnt[1] !== 16'h0) begin
      errors++; $display("FAIL ovf_clear: got ovf=%b dcnt=%h expected 0/0", ovf[1], dcnt[1]);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (present[1] !== 1'b1 || sec[1] !== 40'h200 + 40'(k)) begin
        errors++; $display("FAIL ovf_entry%0d: got present=%b sec=%h expected 1/%h", k, present[1], sec[1], 40'h200 + 40'(k));
      end
      pop = 1'b1;
      step();
      pop = 1'b0;
    end
    checks++;
    if (present[1] !== 1'b0) begin errors++; $display("FAIL ovf_drain: got present=%b expected 0", present[1]); end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    enable = 5'h1F;
    for (int c = 0; c < 5; c++) begin
      trig = 5'h01; tm_sec = 40'h300 + 40'(c);
      step();
    end
    trig = 5'h00; pop = 1'b1;
    step();
    pop = 1'b0;
    checks++;
    if (ovf[1] !== 1'b0) begin errors++; $display("FAIL fullpp_ovf: got %b expected 0", ovf[1]); end
    for (int k = 1; k < 5; k++) begin
      checks++;
      if (present[1] !== 1'b1 || sec[1] !== 40'h300 + 40'(k)) begin
        errors++; $display("FAIL fullpp_entry%0d: got present=%b sec=%h expected 1/%h", k, present[1], sec[1], 40'h300 + 40'(k));
      end
      pop = 1'b1;
      step();
      pop = 1'b0;
    end
    pop = 1'b1;
    step();
    pop = 1'b0;
    checks++;
    if (present[1] !== 1'b0 || ovf[1] !== 1'b0) begin
      errors++; $display("FAIL empty_pop: got present=%b ovf=%b expected 0/0", present[1], ovf[1]);
    end
    trig = 5'h01; tm_sec = 40'h3AA;
    step();
    trig = 5'h00;
    step();
    checks++;
    if (present[1] !== 1'b1 || sec[1] !== 40'h3AA) begin
      errors++; $display("FAIL empty_pop_after: got present=%b sec=%h expected 1/3aa", present[1], sec[1]);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    enable = 5'h1F;
    for (int c = 0; c < 21; c++) begin
      trig   = (c % 9 == 0) ? 5'h01 : 5'h00;
      tm_sec = 40'h400 + 40'(c);
      step();
    end
    checks++;
    if (present[0] !== 1'b1) begin errors++; $display("FAIL resetmid_pre: got present=%b expected 1", present[0]); end
    rst = 1'b1; trig = 5'h01; tm_sec = 40'h4EE;
    step();
    rst = 1'b0; tm_sec = 40'h4F0;
    checks++;
    if (present[0] !== 1'b0 || mask[0] !== 5'h0 || sec[0] !== 40'h0 ||
        cyc[0] !== 28'h0 || ovf[0] !== 1'b0 || dcnt[0] !== 16'h0) begin
      errors++; $display("FAIL resetmid_outputs: got present=%b mask=%h sec=%h cyc=%h ovf=%b dcnt=%h expected all 0",
                         present[0], mask[0], sec[0], cyc[0], ovf[0], dcnt[0]);
    end
    step();
    trig = 5'h00;
    step();
    checks++;
    if (present[0] !== 1'b1 || sec[0] !== 40'h4F0) begin
      errors++; $display("FAIL resetmid_next: got present=%b sec=%h expected 1/4f0", present[0], sec[0]);
    end
  endtask

  task automatic test_random();
    logic [72:0] exp_head;
    apply_reset();
    for (int i = 0; i < 500; i++) begin
      trig    = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'h00;
      enable  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h1F;
      tm_sec  = {$urandom, 8'($urandom)};
      tm_cyc  = 28'($urandom);
      pop     = ($urandom_range(0, 3) == 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 199) == 0);
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (present[d] !== (mq[d].size() > 0)) begin
          errors++; $display("FAIL rand_present dut%0d cyc%0d: got %b expected %b", d, i, present[d], mq[d].size() > 0);
        end
        if (mq[d].size() > 0) begin
          exp_head = mq[d][0];
          checks++;
          if ({mask[d], sec[d], cyc[d]} !== exp_head) begin
            errors++; $display("FAIL rand_head dut%0d cyc%0d: got %h expected %h", d, i, {mask[d], sec[d], cyc[d]}, exp_head);
          end
        end
        checks++;
        if (ovf[d] !== movf[d]) begin
          errors++; $display("FAIL rand_ovf dut%0d cyc%0d: got %b expected %b", d, i, ovf[d], movf[d]);
        end
        checks++;
        if (dcnt[d] !== mdrop[d]) begin
          errors++; $display("FAIL rand_dcnt dut%0d cyc%0d: got %0d expected %0d", d, i, dcnt[d], mdrop[d]);
        end
      end
    end
    trig = 5'h00; pop = 1'b0; ovf_clr = 1'b0; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; trig = 5'h00; enable = 5'h00;
    tm_sec = 40'h0; tm_cyc = 28'h0; pop = 1'b0; ovf_clr = 1'b0;
    test_reset();
    test_single_event();
    test_merge();
    test_holdoff();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
